util_axis_puf_string_encoder: RTL and testbench
===============================================

// Module: util_axis_puf_string_encoder
// PURPOSE
//   Converts each byte on an 8-bit AXI-Stream slave into an 11-character ASCII
//   binary string, "0b" + 8 bit digits + LF, emitted as one 88-bit AXI-Stream beat.
//   Sits between a PUF/byte source and a UART/text sink.
//   Single-register pipeline, full throughput.
// PARAMETERS
//   none (widths fixed: input 8 bits, output 88 bits = 11 chars)
// PORTS
//   aclk           in   1   clock, all logic on rising edge
//   arst           in   1   reset; asynchronous, active-high
//   s_axis_tdata   in   8   input byte
//   s_axis_tvalid  in   1   input valid
//   s_axis_tready  out  1   input ready
//   m_axis_tdata   out  88  encoded string
//   m_axis_tvalid  out  1   output valid
//   m_axis_tready  in   1   output ready
// BEHAVIOUR
//   - Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0.
//     s_axis_tready=0 while arst is high.
//   - s_axis_tready = ~arst & (~m_axis_tvalid | m_axis_tready).
//     Ready is combinational from m_axis_tready; no combinational valid->ready path.
//   - Accept: s_axis_tvalid & s_axis_tready. On that edge, m_axis_tdata <= encode(byte)
//     and m_axis_tvalid <= 1. Latency: 1 clock.
//   - Output handshake m_axis_tvalid & m_axis_tready with no accept that cycle:
//     m_axis_tvalid <= 0. m_axis_tdata holds its last value.
//   - Simultaneous output handshake and accept: the new word replaces the old one.
//     m_axis_tvalid stays 1. Throughput is 1 byte per clock.
//   - While m_axis_tvalid=1 and m_axis_tready=0: m_axis_tdata and m_axis_tvalid
//     hold stable (AXIS rule). No byte is accepted, dropped or duplicated.
//   - Encoding: char i occupies m_axis_tdata[8i+7:8i]. Char 0 (lowest byte) is sent first.
//       char0 = 8'h30 '0'
//       char1 = 8'h62 'b'
//       char(2+k) = 8'h30 + byte[7-k], k=0..7 (MSB digit first)
//       char10 = 8'h0A LF
//   - s_axis_tvalid with no accept: no state change.
//   - Reset mid-transfer discards the pending word.
// STRUCTURE
//   - Shared package: ASCII constants ASCII_ZERO=8'h30, ASCII_B=8'h62, ASCII_LF=8'h0A;
//     localparams CHAR_W=8, STR_CHARS=11.
//   - One combinational sub-module, byte_to_bin_ascii (8 in, 88 out), holds the encode map.
//   - Top holds the output register and handshake logic.
// TESTING
//   1. Reset held, source valid -> s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0.
//   2. Byte 8'hA5, m_axis_tready=1 -> one clock later tvalid=1,
//      tdata=88'h0A31303130303130316230 ("0b10100101\n").
//   3. Bytes 8'h00 then 8'hFF back-to-back, sink ready -> consecutive beats
//      88'h0A30303030303030306230, then 88'h0A31313131313131316230.
//   4. Sink ready=0 for 5 clocks with word pending -> tdata/tvalid stable, s_axis_tready=0,
//      and no byte is consumed. On release the next byte follows with no gap.
//   5. Counting source 0..255, tvalid toggling, random m_axis_tready -> scoreboard sees
//      every byte once, in order, correctly encoded.
//   6. arst asserted while word pending -> tvalid drops to 0 immediately; no stale beat
//      after release.

Source files
------------

// File: rtl/util_axis_puf_string_encoder_pkg.sv
// Shared constants for the byte -> ASCII binary string encoder.
package util_axis_puf_string_encoder_pkg;

    localparam int CHAR_W    = 8;
    localparam int STR_CHARS = 11;
    localparam int STR_W     = CHAR_W * STR_CHARS;

    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;
    localparam logic [CHAR_W-1:0] ASCII_B    = 8'h62;
    localparam logic [CHAR_W-1:0] ASCII_LF   = 8'h0A;

    typedef logic [STR_CHARS-1:0][CHAR_W-1:0] str_t;

endpackage

// File: rtl/util_axis_puf_string_encoder_byte_to_bin_ascii.sv
// Combinational encode map: one byte -> "0b" + 8 binary digits + LF.
// Char 0 sits in the lowest byte so a byte-serial sink sends it first.
module byte_to_bin_ascii
    import util_axis_puf_string_encoder_pkg::*;
(
    input  logic [7:0]       data_byte,
    output logic [STR_W-1:0] ascii_str
);

    str_t chars;

    assign chars[0]  = ASCII_ZERO;
    assign chars[1]  = ASCII_B;
    assign chars[10] = ASCII_LF;

    // Digit k carries bit 7-k, so the MSB is printed first.
    for (genvar k = 0; k < 8; k++) begin : g_digit
        assign chars[2+k] = ASCII_ZERO + {7'd0, data_byte[7-k]};
    end

    assign ascii_str = chars;

endmodule

// File: rtl/util_axis_puf_string_encoder.sv
// AXI-Stream byte -> 88-bit ASCII binary string beat.
// Single output register; ready is passed back combinationally so a
// continuously-ready sink sees one beat per clock.
module util_axis_puf_string_encoder
    import util_axis_puf_string_encoder_pkg::*;
(
    input  logic             aclk,
    input  logic             arst,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [STR_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [STR_W-1:0] enc_str;
    logic             accept;

    byte_to_bin_ascii u_enc (
        .data_byte (s_axis_tdata),
        .ascii_str (enc_str)
    );

    // Free slot when empty or the held word leaves this cycle; never ready in reset.
    assign s_axis_tready = ~arst & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Output register: load on accept, clear valid once the word is taken.
    // Data is left untouched on drain so the bus does not toggle needlessly.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= enc_str;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_util_axis_puf_string_encoder.sv
// Scoreboard bench for util_axis_puf_string_encoder.
// Inputs change only just after a rising edge; the monitor samples on the
// falling edge, so whatever it sees is exactly what the next rising edge uses.
module tb_util_axis_puf_string_encoder;

    logic        tb_data_clk = 1'b0;
    logic        arst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [87:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    int checks = 0;
    int errors = 0;
    logic [87:0] exp_q[$];

    always #5 tb_data_clk = ~tb_data_clk;

    util_axis_puf_string_encoder dut (
        .aclk          (tb_data_clk),
        .arst          (arst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // Reference: build the text string, then lay char i into byte lane i.
    function automatic logic [87:0] model_enc(input logic [7:0] b);
        string       s;
        logic [87:0] w;
        s = {"0b", $sformatf("%08b", b), "\n"};
        w = '0;
        for (int i = 0; i < 11; i++) w[8*i +: 8] = s[i];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [87:0] got, input logic [87:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Monitor: push on input handshake, pop/compare on output handshake,
    // and verify the output holds while the sink stalls.
    logic        prev_stall = 1'b0;
    logic [87:0] prev_data  = '0;
    always @(negedge tb_data_clk) begin
        if (arst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {87'd0, m_axis_tvalid}, 88'd1);
                chk("stall_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_axis_tdata, 88'd0);
                    if (m_axis_tdata == 88'd0) begin
                        errors++;
                        $display("FAIL unexpected_beat got %h exp none", m_axis_tdata);
                    end
                end else begin
                    chk("sb_data", m_axis_tdata, exp_q.pop_front());
                end
            end
            if (s_axis_tvalid && s_axis_tready) exp_q.push_back(model_enc(s_axis_tdata));
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    // Global time bound.
    initial begin
        #400000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge tb_data_clk);
        #1;
    endtask

    initial begin
        int cnt;
        int cyc;
        logic acc;

        // 1. reset held with source valid
        arst          = 1'b1;
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge tb_data_clk);
        chk("rst_s_ready", {87'd0, s_axis_tready}, 88'd0);
        chk("rst_m_valid", {87'd0, m_axis_tvalid}, 88'd0);
        chk("rst_m_data", m_axis_tdata, 88'd0);
        step();
        arst          = 1'b0;
        s_axis_tvalid = 1'b0;

        // 2. single byte, one clock latency
        step();
        s_axis_tdata  = 8'hA5;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        @(negedge tb_data_clk);
        chk("a5_valid", {87'd0, m_axis_tvalid}, 88'd1);
        chk("a5_data", m_axis_tdata, 88'h0A31303130303130316230);

        // 3. back-to-back 00, FF
        step();
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tdata  = 8'hFF;
        @(negedge tb_data_clk);
        chk("b2b_00", m_axis_tdata, 88'h0A30303030303030306230);
        step();
        s_axis_tvalid = 1'b0;
        @(negedge tb_data_clk);
        chk("b2b_ff_valid", {87'd0, m_axis_tvalid}, 88'd1);
        chk("b2b_ff", m_axis_tdata, 88'h0A31313131313131316230);

        // 4. sink stall with a word pending and the next byte waiting
        step();
        m_axis_tready = 1'b0;
        s_axis_tdata  = 8'h3C;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tdata  = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_data_clk);
            chk("hold_valid", {87'd0, m_axis_tvalid}, 88'd1);
            chk("hold_data", m_axis_tdata, model_enc(8'h3C));
            chk("hold_s_ready", {87'd0, s_axis_tready}, 88'd0);
        end
        step();
        m_axis_tready = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        @(negedge tb_data_clk);
        chk("release_valid", {87'd0, m_axis_tvalid}, 88'd1);
        chk("release_data", m_axis_tdata, model_enc(8'h5A));

        // 5. counting source, random valid and ready
        cnt = 0;
        cyc = 0;
        s_axis_tdata  = 8'd0;
        s_axis_tvalid = 1'b0;
        while (cnt < 256 && cyc < 20000) begin
            @(negedge tb_data_clk);
            acc = s_axis_tvalid && s_axis_tready;
            step();
            cyc++;
            if (acc) cnt++;
            if (!s_axis_tvalid || acc) begin
                s_axis_tvalid = (cnt < 256) && ($urandom_range(0, 1) == 1);
                s_axis_tdata  = cnt[7:0];
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
        chk("count_done", 88'(cnt), 88'd256);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) step();
        chk("sb_drained", 88'(exp_q.size()), 88'd0);

        // 6. reset while a word is pending
        m_axis_tready = 1'b0;
        s_axis_tdata  = 8'hC3;
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        @(negedge tb_data_clk);
        chk("pend_valid", {87'd0, m_axis_tvalid}, 88'd1);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_valid", {87'd0, m_axis_tvalid}, 88'd0);
        chk("arst_data", m_axis_tdata, 88'd0);
        chk("arst_s_ready", {87'd0, s_axis_tready}, 88'd0);
        exp_q.delete();
        repeat (2) step();
        arst          = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_data_clk);
            chk("post_rst_valid", {87'd0, m_axis_tvalid}, 88'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
